// File: rtl/wishbone_ctrl_pkg.sv
// Shared types for the single-transfer Wishbone Classic controller.
package wishbone_ctrl_pkg;

    localparam int ADR_W_DEF = 8;
    localparam int DAT_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [ADR_W_DEF-1:0] adr;
        logic [DAT_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/wishbone_timeout_counter.sv
// ACK wait counter: cleared while idle, counts un-acknowledged BUSY cycles,
// flags expiry combinationally on the edge the count would reach LIMIT.
module wishbone_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr_i) begin
            count <= '0;
        end else if (en_i) begin
            count <= count + 16'd1;
        end
    end

    assign expire_o = en_i && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/wishbone_ctrl_classic.sv
// Single-transfer Wishbone B4 Classic controller (one cycle per command).
// Optional ACK timeout compiled in with `define WB_CTRL_TIMEOUT_EN.
module wishbone_ctrl_classic
    import wishbone_ctrl_pkg::*;
#(
    parameter int ADR_WIDTH      = ADR_W_DEF,
    parameter int DAT_WIDTH      = DAT_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [DAT_WIDTH-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    output logic [DAT_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADR_WIDTH-1:0] wb_adr_o,
    output logic [DAT_WIDTH-1:0] wb_dat_o,
    input  logic [DAT_WIDTH-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    state_t state;
    logic   timeout;

    assign cmd_ready_o = (state == IDLE);
    assign wb_stb_o    = wb_cyc_o;

`ifdef WB_CTRL_TIMEOUT_EN
    logic to_expire;

    wishbone_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state == IDLE),
        .en_i    ((state == BUSY) && !wb_ack_i),
        .expire_o(to_expire)
    );

    assign timeout = to_expire;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wb_we_o  <= cmd_we_i;
                        wb_adr_o <= cmd_adr_i;
                        wb_dat_o <= cmd_wdata_i;
                        wb_cyc_o <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // ACK beats a timeout that lands on the same edge
                    if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        if (!wb_we_o) begin
                            rsp_rdata_o <= wb_dat_i;
                        end
                        state <= IDLE;
                    end else if (timeout) begin
                        wb_cyc_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
